// File: rtl/prog_feeder_pkg.sv
// Shared constants and types for the program feeder: opcodes, state encoding,
// word/address widths and the Done watchdog limit.
package prog_feeder_pkg;

  localparam int WORD_W = 9;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;
  localparam int WDOG_W = 4;

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 4'd15;
  localparam logic [CNT_W-1:0]  CNT_MAX    = 8'hFF;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_IMM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic [2:0] opcode_of(input word_t w);
    return w[WORD_W-1 -: 3];
  endfunction

endpackage

// File: rtl/prog_feeder_mem.sv
// 32x9 program memory: synchronous write, asynchronous read (a same-cycle
// read of the written address returns the old word).
module prog_mem
  import prog_feeder_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  word_t mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_feeder.sv
// Feeds a stored program word-by-word to a simple processor, handshaking on
// Done, with a Done watchdog and an instruction counter.
//   state | meaning
//   IDLE  | waiting for Start after reset
//   ISSUE | present mem[PC], pulse Run unless the word is the HALT sentinel
//   IMM   | present the immediate word of an mvi
//   WAIT  | hold last word until Done or watchdog expiry
//   HALT  | program ended (sentinel or timeout); Start restarts
module prog_feeder
  import prog_feeder_pkg::*;
(
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              start_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              done_i,
  output logic [WORD_W-1:0] din_o,
  output logic              run_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [CNT_W-1:0]  instr_count_o
);

  state_e             state_q, state_d;
  addr_t              pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               err_q, err_d;
  word_t              hold_q, hold_d;
  word_t              rdata;
  logic               busy;

  assign busy = (state_q == ST_ISSUE) || (state_q == ST_IMM) || (state_q == ST_WAIT);

  prog_mem u_mem (
    .clk_i   (clk_i),
    .we_i    (load_en_i && !busy),
    .waddr_i (load_addr_i),
    .wdata_i (load_data_i),
    .raddr_i (pc_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d = ST_ISSUE;
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        hold_d = rdata;
        wdog_d = '0;
        if (opcode_of(rdata) == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = (opcode_of(rdata) == OP_MVI) ? ST_IMM : ST_WAIT;
        end
      end
      ST_IMM, ST_WAIT: begin
        if (state_q == ST_IMM) begin
          hold_d = rdata;
          pc_d   = pc_q + 1'b1;
        end
        if (done_i) begin
          state_d = ST_ISSUE;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (state_q == ST_IMM) begin
          // IMM -> WAIT is a fresh WAIT entry, so the watchdog restarts
          state_d = ST_WAIT;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WDOG_LIMIT - 1'b1) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_o = 1'b0;
    din_o = '0;
    case (state_q)
      ST_ISSUE: begin
        din_o = rdata;
        run_o = (opcode_of(rdata) != OP_HALT);
      end
      ST_IMM:  din_o = rdata;
      ST_WAIT: din_o = hold_q;
      default: ;
    endcase
  end

  assign busy_o        = busy;
  assign halted_o      = (state_q == ST_HALT);
  assign error_o       = err_q;
  assign pc_o          = pc_q;
  assign instr_count_o = cnt_q;

endmodule
